cmp_pipe_unit: RTL
==================

# cmp_pipe_unit

Parametrised, pipelined magnitude comparator with enable, signed/unsigned mode, valid handshake, change detection and per-outcome saturating event counters. It replaces the fixed 4-bit single-mode comparator in the frequency-divider datapath. The control FSM sends operand pairs to this block and reads back a registered one-hot result plus running statistics.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- CNT_W, 8, width of each event counter (≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  1: comparator active; 0: pipeline flushed, result outputs cleared, counters hold
- in_valid  in  1  A/B/signed_mode sampled this cycle when en=1
- signed_mode  in  1  1: A, B two's complement; 0: unsigned; captured with the operands
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- clr_cnt  in  1  synchronous clear of all three counters
- out_valid  out  1  one-cycle pulse: G/L/E/changed carry a new result
- G  out  1  A > B (last valid result)
- L  out  1  A < B (last valid result)
- E  out  1  A == B (last valid result)
- changed  out  1  with out_valid: result differs from previous valid result
- g_cnt  out  CNT_W  count of G results, saturating
- l_cnt  out  CNT_W  count of L results, saturating
- e_cnt  out  CNT_W  count of E results, saturating

## Operation
- Stage 1 (capture): on a clock edge with en=1 and in_valid=1, register A, B, signed_mode; set s1_valid. Otherwise, clear s1_valid.
- Stage 2 (compare): when s1_valid=1, compute the ordering from the captured mode.
  - Signed: MSB-inverted compare, or an equivalent method.
  - Unsigned: plain magnitude compare.
  - Register exactly one of G/L/E. Pulse out_valid for one cycle.
- G/L/E hold the last result between valid results. They are always one-hot or all-zero.
- changed is 1 with out_valid when the new one-hot differs from the previous valid one-hot. It is also 1 on the first result after reset or after en was low. It is 0 whenever out_valid=0.
- Counters:
  - On out_valid, the counter matching the result increments by 1.
  - At 2^CNT_W−1 the counter holds; it does not wrap.
  - clr_cnt=1 zeroes all counters. If clr_cnt coincides with an increment, the clear wins and the counter reads 0.
  - clr_cnt acts regardless of en.
- en=0, synchronous on the clock edge:
  - s1_valid cleared; in-flight operands discarded.
  - out_valid, G, L, E, changed driven to 0.
  - "Previous result" history cleared.
  - Counters hold, except that clr_cnt is still honoured.
- Back-to-back in_valid is accepted every cycle. There is no backpressure; throughput is one comparison per clock.
- Mode is applied per operand pair. Toggling signed_mode between consecutive inputs is legal.

## Timing
- Reset (async assert, sync-safe release): s1_valid=0, out_valid=0, G=L=E=0, changed=0, history=none, g_cnt=l_cnt=e_cnt=0.
- Latency: in_valid at edge N results in out_valid and G/L/E updated after edge N+1. A result is visible 2 edges after the operands were presented.
- Counters update on the same edge as out_valid, so they are visible alongside the result.
- en falling at edge N: the operand sampled at N−1 is lost, and outputs are 0 after edge N.
- en rising: the first in_valid is accepted on the same edge where en=1 is sampled.
- A reset mid-pipeline discards all in-flight data immediately.

## Test plan
- Reset, then WIDTH=8 unsigned inputs A=0xC8, B=0x32 → 2 cycles later out_valid=1, G=1, L=E=0, changed=1, g_cnt=1.
- Signed mode: A=0xFF (−1), B=0x01 → L=1. The same pair with signed_mode=0 on the next cycle → G=1, changed=1. Throughput is one result per clock.
- Three consecutive A=B=0x55 → E=1 on each; changed=1, 0, 0; e_cnt=3. With in_valid low afterwards, G/L/E hold and out_valid=0.
- CNT_W=2: drive 5 G results → g_cnt saturates at 3. Assert clr_cnt together with a 6th G result → g_cnt=0.
- en dropped while one operand is in flight → no out_valid for that operand, and G=L=E=0. Re-enable and send A<B → L=1, changed=1. Counters keep their pre-disable values plus 1 in l_cnt.
- Assert async rst between clock edges with results pending → all outputs and counters 0 immediately. No out_valid after release until a new in_valid.

Source files
------------

// File: rtl/cmp_pipe_unit.sv
// Two-stage pipelined magnitude comparator: stage 1 captures operands and mode,
// stage 2 registers a one-hot G/L/E result, a change flag and saturating per-outcome counters.
module cmp_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic             G,
    output logic             L,
    output logic             E,
    output logic             changed,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] l_cnt,
    output logic [CNT_W-1:0] e_cnt
);

    // Handshake: in_valid qualifies A/B/signed_mode on any edge with en=1; there is
    // no ready, every offered pair is taken. out_valid is a one-cycle pulse that
    // qualifies G/L/E/changed two edges later; the consumer cannot stall it.

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic             s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= en & in_valid;
            if (en && in_valid) begin
                a_q    <= A;
                b_q    <= B;
                mode_q <= signed_mode;
            end
        end
    end

    // Flipping the MSB maps two's complement order onto unsigned order.
    logic [WIDTH-1:0] msb_flip;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             gt;
    logic             lt;
    logic             eq;
    logic [2:0]       new_res;

    always_comb begin
        msb_flip = '0;
        msb_flip[WIDTH-1] = mode_q;
        a_key   = a_q ^ msb_flip;
        b_key   = b_q ^ msb_flip;
        gt      = a_key > b_key;
        lt      = a_key < b_key;
        eq      = ~gt & ~lt;
        new_res = {gt, lt, eq};
    end

    // G/L/E double as the result history: all-zero means "no previous result",
    // so the first result after reset or disable always reports changed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            G         <= 1'b0;
            L         <= 1'b0;
            E         <= 1'b0;
            changed   <= 1'b0;
        end else if (!en) begin
            out_valid <= 1'b0;
            G         <= 1'b0;
            L         <= 1'b0;
            E         <= 1'b0;
            changed   <= 1'b0;
        end else if (s1_valid) begin
            out_valid   <= 1'b1;
            {G, L, E}   <= new_res;
            changed     <= (new_res != {G, L, E});
        end else begin
            out_valid <= 1'b0;
            changed   <= 1'b0;
        end
    end

    logic count_now;
    assign count_now = en & s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cnt <= '0;
            l_cnt <= '0;
            e_cnt <= '0;
        end else if (clr_cnt) begin
            g_cnt <= '0;
            l_cnt <= '0;
            e_cnt <= '0;
        end else if (count_now) begin
            if (gt && (g_cnt != '1)) g_cnt <= g_cnt + CNT_W'(1);
            if (lt && (l_cnt != '1)) l_cnt <= l_cnt + CNT_W'(1);
            if (eq && (e_cnt != '1)) e_cnt <= e_cnt + CNT_W'(1);
        end
    end

endmodule
